alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Command queue and result register that sits directly upstream of the ALU and captures what it produces. It buffers {A, B, funct, tag} commands from the decode side in a FIFO and presents the head entry to the combinational ALU's A/B/funct/enable inputs. On the following clock edge it registers the ALU's out/flags into a result slot with a valid/ready handshake toward writeback.

## Interface
- WIDTH, 32, operand/result width; matches ALU WIDTH
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_W, 4, width of the opaque destination tag carried alongside each command

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk edge
- in_valid  in  1  command offered
- in_ready  out  1  queue can accept a command this cycle
- in_A, in_B  in  WIDTH  operands
- in_funct  in  6  ALU function code
- in_tag  in  TAG_W  destination tag
- alu_A, alu_B  out  WIDTH  to ALU A/B
- alu_funct  out  6  to ALU funct
- alu_enable  out  1  to ALU enable; high only when the head is issued this cycle
- alu_out  in  WIDTH  from ALU out (combinational from alu_* this cycle)
- alu_flags  in  4  from ALU flags
- res_valid  out  1  result slot full
- res_ready  in  1  writeback consumes result
- res_data  out  WIDTH  captured alu_out
- res_flags  out  4  captured alu_flags
- res_tag  out  TAG_W  tag of captured command
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- The FIFO is a circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0. count tracks occupancy, 0..DEPTH.
- Push condition: in_valid && in_ready. in_ready = (count != DEPTH). A command offered while full is ignored and left unchanged by the queue; the upstream stage holds it.
- Issue condition: issue = !empty && (!res_valid || res_ready).
  - On issue, alu_enable = 1, and alu_A/alu_B/alu_funct carry the head entry.
  - When not issuing, alu_enable = 0 and alu_* hold the head entry, or 0 if empty.
- On a clock edge with issue:
  - res_data ← alu_out, res_flags ← alu_flags, res_tag ← head tag.
  - res_valid ← 1, and the FIFO pops (rd_ptr++).
- On a clock edge with res_valid && res_ready && !issue: res_valid ← 0.
- A push and a pop on the same edge leave count unchanged, and both pointers advance. This is legal at any count 1..DEPTH-1. At count = DEPTH, no push occurs even if a pop does, because in_ready was 0 that cycle.
- A push into an empty queue is not issued on the same cycle, except with the bypass macro (see Configuration).
- Commands are issued and results are produced strictly in acceptance order.
- Full throughput is one command per cycle while res_ready is held high.
- When res_ready = 0, the result slot and FIFO contents are frozen. The FIFO keeps accepting until full.

## Timing
- Reset values:
  - count = 0, rd_ptr = wr_ptr = 0
  - res_valid = 0, res_data = 0, res_flags = 0, res_tag = 0
  - in_ready = 1 (combinational from count)
  - alu_enable = 0, alu_* = 0
- Reset asserted mid-operation discards all queued commands and any pending result at that edge. Handshakes seen in the reset cycle are ignored.
- Latency: a command accepted at edge k into an empty queue with a free result slot is issued in cycle k+1. res_valid goes high after edge k+1, so accept-to-result is 2 edges.
- The ALU path is combinational within one cycle: alu_* registered/mux outputs → alu_out → res_data flop.
- in_ready depends only on registered count, with no combinational path from res_ready to in_ready.

## Configuration
- ALU_ISSUE_BYPASS_EN defined:
  - When the FIFO is empty and in_valid && (!res_valid || res_ready), in_A/in_B/in_funct/in_tag drive alu_* directly and alu_enable = 1.
  - The result is captured at the same edge, and the command is not written into the FIFO.
  - Accept-to-result latency becomes 1 edge.
  - in_ready adds no combinational dependency beyond count.
- ALU_ISSUE_BYPASS_EN undefined: there is no bypass and latency is always ≥2 edges, as specified above.

## Test plan
The bench uses an ALU stub with alu_out = alu_A + alu_B and alu_flags = alu_funct[3:0].
- Reset and single command: after reset, assert in_valid with in_A=32'hFA10_070F, in_B=32'h0000_010F, funct=3, tag=5, res_ready=1.
  - Required: res_valid high 2 edges later, res_data=32'hFA10_081E, res_flags=4'h3, res_tag=5.
  - Required with ALU_ISSUE_BYPASS_EN: res_valid high 1 edge later.
- Streaming: push funct 0..7 back-to-back with res_ready=1.
  - Required: 8 consecutive res_valid cycles, res_flags 0..7 in order, count never exceeds 1 (0 with bypass).
- Backpressure and full: hold res_ready=0 and push 6 commands.
  - Required: 1 result captured, count=DEPTH=4, in_ready=0, 6th command not accepted until res_ready=1.
  - Required: after release, remaining results drain in order.
- Simultaneous push/pop at count=2 with res_ready=1.
  - Required: count stays 2, wr_ptr and rd_ptr both advance.
  - Required: pointer wrap 3→0 exercised with no lost or duplicated tag.
- Reset mid-stream: with count=3 and res_valid=1, assert reset for one edge.
  - Required: count=0, res_valid=0, in_ready=1 next cycle.
  - Required: no stale result appears afterwards.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO feeding a combinational ALU, with a registered result slot; ALU_ISSUE_BYPASS_EN enables empty-queue bypass.
module alu_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_A,
  input  logic [WIDTH-1:0]         in_B,
  input  logic [5:0]               in_funct,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [WIDTH-1:0]         alu_A,
  output logic [WIDTH-1:0]         alu_B,
  output logic [5:0]               alu_funct,
  output logic                     alu_enable,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic [3:0]               alu_flags,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [3:0]               res_flags,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] qa [DEPTH];
  logic [WIDTH-1:0] qb [DEPTH];
  logic [5:0]       qf [DEPTH];
  logic [TAG_W-1:0] qt [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             empty, slot_free, issue_q, byp, issue, push, pop;
  logic [TAG_W-1:0] head_tag;
  assign empty     = (count == '0);
  assign in_ready  = (count != CW'(DEPTH));
  assign slot_free = !res_valid || res_ready;
  assign issue_q   = !empty && slot_free;
`ifdef ALU_ISSUE_BYPASS_EN
  // An empty queue hands the incoming command straight to the ALU instead of storing it
  assign byp = empty && in_valid && slot_free;
`else
  assign byp = 1'b0;
`endif
  assign issue = issue_q || byp;
  assign push  = in_valid && in_ready && !byp;
  assign pop   = issue_q;
  always_comb begin
    alu_enable = issue;
    alu_A      = byp ? in_A : empty ? '0 : qa[rd_ptr];
    alu_B      = byp ? in_B : empty ? '0 : qb[rd_ptr];
    alu_funct  = byp ? in_funct : empty ? '0 : qf[rd_ptr];
    head_tag   = byp ? in_tag : qt[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (push) begin
      qa[wr_ptr] <= in_A;
      qb[wr_ptr] <= in_B;
      qf[wr_ptr] <= in_funct;
      qt[wr_ptr] <= in_tag;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      res_tag   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (issue) begin
        res_valid <= 1'b1;
        res_data  <= alu_out;
        res_flags <= alu_flags;
        res_tag   <= head_tag;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed checks of alu_issue_queue against an adder ALU stub.
module tb_alu_issue_queue;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, alu_enable, res_valid, res_ready;
  logic [31:0] in_A, in_B, alu_A, alu_B, alu_out, res_data;
  logic [5:0]  in_funct, alu_funct;
  logic [3:0]  in_tag, alu_flags, res_flags, res_tag;
  logic [2:0]  count;
  int errors = 0;
  int checks = 0;
`ifdef ALU_ISSUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  alu_issue_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_funct(in_funct), .in_tag(in_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_funct(alu_funct), .alu_enable(alu_enable),
    .alu_out(alu_out), .alu_flags(alu_flags), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags), .res_tag(res_tag), .count(count)
  );
  assign alu_out   = alu_A + alu_B;
  assign alu_flags = alu_funct[3:0];
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cmd(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f, input logic [3:0] t);
    in_valid = v; in_A = a; in_B = b; in_funct = f; in_tag = t;
  endtask
  initial begin
    int exp_n, nvalid, first, last;
    logic acc;
    logic [3:0] t;
    reset = 1'b1; res_ready = 1'b0;
    cmd(1'b0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_flags", res_flags, 0);
    // single command
    res_ready = 1'b1;
    cmd(1'b1, 32'hFA10_070F, 32'h0000_010F, 6'd3, 4'd5);
    #1 chk("single_enable_pre", alu_enable, BYP);
    step();
    in_valid = 1'b0;
    if (BYP == 0) begin
      chk("single_count", count, 1);
      chk("single_res_valid_early", res_valid, 0);
      chk("single_issue_enable", alu_enable, 1);
      chk("single_issue_A", alu_A, 32'hFA10_070F);
      step();
    end
    chk("single_res_valid", res_valid, 1);
    chk("single_res_data", res_data, 32'hFA10_081E);
    chk("single_res_flags", res_flags, 4'h3);
    chk("single_res_tag", res_tag, 5);
    step();
    chk("single_consumed", res_valid, 0);
    // streaming
    exp_n = 0; nvalid = 0; first = -1; last = -1;
    for (int i = 0; i < 10; i++) begin
      cmd(i < 8, i, 100, 6'(i), 4'(i));
      step();
      chk("stream_count_max", count <= 3'(1 - BYP), 1);
      if (res_valid) begin
        chk("stream_flags", res_flags, exp_n);
        chk("stream_data", res_data, exp_n + 100);
        if (first < 0) first = i;
        last = i; exp_n++; nvalid++;
      end
    end
    in_valid = 1'b0;
    chk("stream_nvalid", nvalid, 8);
    chk("stream_consecutive", last - first + 1, 8);
    step();
    chk("stream_idle", res_valid, 0);
    // backpressure and full
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cmd(1'b1, i, 0, 6'(i), 4'(i));
      step();
    end
    cmd(1'b1, 6, 0, 6'd6, 4'd6);
    step(); step();
    chk("bp_count", count, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_res_valid", res_valid, 1);
    chk("bp_res_tag", res_tag, 1);
    chk("bp_res_data", res_data, 1);
    chk("bp_alu_enable", alu_enable, 0);
    res_ready = 1'b1;
    exp_n = 2;
    for (int i = 0; i < 12; i++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
      if (res_valid && exp_n <= 6) begin
        chk("bp_drain_tag", res_tag, exp_n);
        chk("bp_drain_data", res_data, exp_n);
        exp_n++;
      end
    end
    chk("bp_drained", exp_n, 7);
    chk("bp_empty", count, 0);
    // simultaneous push/pop at count 2 with pointer wrap
    reset = 1'b1; step(); reset = 1'b0;
    res_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cmd(1'b1, 0, 0, 0, 4'(10 + j));
      step();
    end
    chk("pp_count_init", count, 2);
    chk("pp_wr_init", dut.wr_ptr, 3 - BYP);
    chk("pp_rd_init", dut.rd_ptr, 1 - BYP);
    chk("pp_tag_init", res_tag, 10);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      t = 4'(13 + k);
      cmd(1'b1, 0, 0, 0, t);
      step();
      chk("pp_count", count, 2);
      chk("pp_wr", dut.wr_ptr, (3 - BYP + k + 1) % 4);
      chk("pp_rd", dut.rd_ptr, (1 - BYP + k + 1) % 4);
      chk("pp_tag", res_tag, 11 + k);
    end
    in_valid = 1'b0;
    step();
    chk("pp_drain_tag0", res_tag, 0);
    step();
    chk("pp_drain_tag1", res_tag, 1);
    chk("pp_drain_valid", res_valid, 1);
    step();
    chk("pp_idle", res_valid, 0);
    // reset mid-stream
    res_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cmd(1'b1, 0, 0, 0, 4'(2 + j));
      step();
    end
    chk("mid_count_pre", count, 3);
    chk("mid_valid_pre", res_valid, 1);
    reset = 1'b1; res_ready = 1'b1;
    cmd(1'b1, 7, 7, 6'd9, 4'd9);
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("mid_count", count, 0);
    chk("mid_res_valid", res_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_res_tag", res_tag, 0);
    chk("mid_alu_enable", alu_enable, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", res_valid, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
